// File: rtl/hazard_pkg.sv
// Shared constants for the issue scoreboard: latency classes and index widths.
package hazard_pkg;

  localparam int unsigned LAT_W     = 3;
  localparam int unsigned MAX_LAT   = 4;
  localparam int unsigned REG_IDX_W = 5;

  localparam logic [LAT_W-1:0] LAT_ALU  = 3'd0;
  localparam logic [LAT_W-1:0] LAT_LOAD = 3'd1;
  localparam logic [LAT_W-1:0] LAT_MUL  = 3'd3;

endpackage

// File: rtl/sb_reg_timer.sv
// Per-register cycles-until-available counter: loads a latency on issue, else counts down to 0.
module sb_reg_timer #(
  parameter int unsigned LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [LAT_W-1:0] lat_i,
  output logic [LAT_W-1:0] cnt_o,
  output logic             busy_o
);

  logic [LAT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = lat_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/issue_scoreboard.sv
// ID-stage issue gate: per-register latency timers, write-back port reservations and
// RAW/WAW/port hazard detection driving the single IF/ID stall line.
module issue_scoreboard #(
  parameter int unsigned NREG    = 32,
  parameter int unsigned MAX_LAT = hazard_pkg::MAX_LAT,
  parameter int unsigned LAT_W   = hazard_pkg::LAT_W,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            id_valid_i,
  input  logic [hazard_pkg::REG_IDX_W-1:0] rs1_i,
  input  logic [hazard_pkg::REG_IDX_W-1:0] rs2_i,
  input  logic                            rs1_used_i,
  input  logic                            rs2_used_i,
  input  logic [hazard_pkg::REG_IDX_W-1:0] rd_i,
  input  logic                            rd_we_i,
  input  logic [LAT_W-1:0]                lat_i,
  input  logic                            flush_i,
  output logic                            stall_o,
  output logic                            issue_o,
  output logic                            raw_stall_o,
  output logic                            waw_stall_o,
  output logic                            wb_stall_o,
  output logic [NREG-1:0]                 busy_o,
  output logic [CNT_W-1:0]                stall_cnt_o
);

  import hazard_pkg::*;

  logic [NREG-1:0][LAT_W-1:0] cnt;
  logic [MAX_LAT:0]           wb_sched_q, wb_sched_d;
  logic [CNT_W-1:0]           stall_cnt_q, stall_cnt_d;
  logic                       raw1, raw2, raw, waw, wb_hit;
  logic                       issue_wr;

  // x0 is hardwired: never busy, never blocks.
  assign cnt[0]    = '0;
  assign busy_o[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_timer
    sb_reg_timer #(
      .LAT_W (LAT_W)
    ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load_i (issue_wr && (rd_i == REG_IDX_W'(r))),
      .lat_i  (lat_i),
      .cnt_o  (cnt[r]),
      .busy_o (busy_o[r])
    );
  end

  always_comb begin
    raw1 = rs1_used_i && (rs1_i != '0) && (cnt[rs1_i] != '0);
    raw2 = rs2_used_i && (rs2_i != '0) && (cnt[rs2_i] != '0);
    raw  = id_valid_i && (raw1 || raw2);
    waw  = id_valid_i && rd_we_i && (rd_i != '0) && (cnt[rd_i] > lat_i);
    // Port conflict: a booked write-back would land in the same cycle as ours.
    // lat_i == MAX_LAT looks one slot past the vector, which is always free.
    wb_hit = 1'b0;
    for (int k = 0; k < int'(MAX_LAT); k++) begin
      if (lat_i == LAT_W'(k) && wb_sched_q[k+1]) begin
        wb_hit = 1'b1;
      end
    end
    wb_hit = wb_hit && id_valid_i && rd_we_i;
  end

  assign raw_stall_o = raw;
  assign waw_stall_o = waw;
  assign wb_stall_o  = wb_hit;
  assign stall_o     = raw | waw | wb_hit;
  assign issue_o     = id_valid_i & ~stall_o & ~flush_i;
  assign issue_wr    = issue_o && rd_we_i && (rd_i != '0);

  always_comb begin
    wb_sched_d = wb_sched_q >> 1;
    if (issue_wr) begin
      for (int k = 0; k <= int'(MAX_LAT); k++) begin
        if (lat_i == LAT_W'(k)) begin
          wb_sched_d[k] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_sched_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      wb_sched_q  <= wb_sched_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: load-use, mul chains, WAW, port conflict, flush,
// x0, stall-counter saturation and asynchronous reset.
module tb_issue_scoreboard;

  localparam int unsigned NREG  = 32;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid_i;
  logic [4:0]       rs1_i, rs2_i, rd_i;
  logic             rs1_used_i, rs2_used_i, rd_we_i, flush_i;
  logic [2:0]       lat_i;
  logic             stall_o, issue_o, raw_stall_o, waw_stall_o, wb_stall_o;
  logic [NREG-1:0]  busy_o;
  logic [CNT_W-1:0] stall_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  issue_scoreboard #(
    .NREG    (NREG),
    .MAX_LAT (4),
    .LAT_W   (3),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid_i  (id_valid_i),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .rs1_used_i  (rs1_used_i),
    .rs2_used_i  (rs2_used_i),
    .rd_i        (rd_i),
    .rd_we_i     (rd_we_i),
    .lat_i       (lat_i),
    .flush_i     (flush_i),
    .stall_o     (stall_o),
    .issue_o     (issue_o),
    .raw_stall_o (raw_stall_o),
    .waw_stall_o (waw_stall_o),
    .wb_stall_o  (wb_stall_o),
    .busy_o      (busy_o),
    .stall_cnt_o (stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive the ID slot just after the falling edge, then settle before sampling.
  task automatic drive(input logic v, input logic [4:0] s1, input logic u1,
                       input logic [4:0] s2, input logic u2, input logic [4:0] d,
                       input logic we, input logic [2:0] lat, input logic fl);
    @(negedge clk);
    id_valid_i = v;  rs1_i = s1; rs1_used_i = u1; rs2_i = s2; rs2_used_i = u2;
    rd_i = d; rd_we_i = we; lat_i = lat; flush_i = fl;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    id_valid_i = 1'b0; rs1_i = '0; rs2_i = '0; rs1_used_i = 1'b0; rs2_used_i = 1'b0;
    rd_i = '0; rd_we_i = 1'b0; lat_i = '0; flush_i = 1'b0;
    #12;
    check("rst_busy", 32'(busy_o), 32'h0);
    check("rst_cnt", 32'(stall_cnt_o), 32'h0);
    check("rst_stall", 32'(stall_o), 32'h0);
    check("rst_issue", 32'(issue_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Load-use: lw x5 (lat 1), then add x6, x5, x1 -> one bubble.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 3'd1, 1'b0);
    check("lu_load_issue", 32'(issue_o), 32'h1);
    drive(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 3'd0, 1'b0);
    check("lu_stall", 32'(stall_o), 32'h1);
    check("lu_raw", 32'(raw_stall_o), 32'h1);
    check("lu_issue0", 32'(issue_o), 32'h0);
    check("lu_busy", 32'(busy_o), 32'h0000_0020);
    drive(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 3'd0, 1'b0);
    check("lu_issue1", 32'(issue_o), 32'h1);
    check("lu_busy_clr", 32'(busy_o), 32'h0);
    idle();
    check("lu_stall_cnt", 32'(stall_cnt_o), 32'd1);

    // mul x7 (lat 3) immediately followed by a consumer -> three bubbles.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 3'd3, 1'b0);
    check("mul_issue", 32'(issue_o), 32'h1);
    drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 3'd0, 1'b0);
    check("mul_busy", 32'(busy_o), 32'h0000_0080);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 3'd0, 1'b0);
      check("mul_stall", 32'(stall_o), 32'h1);
    end
    drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 3'd0, 1'b0);
    check("mul_issue_after3", 32'(issue_o), 32'h1);
    idle();
    check("mul_stall_cnt", 32'(stall_cnt_o), 32'd4);

    // Same chain with one independent op between -> two bubbles.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 3'd3, 1'b0);
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 3'd0, 1'b0);
    check("mul2_indep_issue", 32'(issue_o), 32'h1);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 3'd0, 1'b0);
      check("mul2_stall", 32'(stall_o), 32'h1);
    end
    drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 3'd0, 1'b0);
    check("mul2_issue", 32'(issue_o), 32'h1);
    idle();
    check("mul2_stall_cnt", 32'(stall_cnt_o), 32'd6);

    // WAW: mul x9 (lat 3) then ALU write to x9 (lat 0).
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 3'd3, 1'b0);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 3'd0, 1'b0);
    check("waw_flag", 32'(waw_stall_o), 32'h1);
    check("waw_noraw", 32'(raw_stall_o), 32'h0);
    check("waw_nowb", 32'(wb_stall_o), 32'h0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 3'd0, 1'b0);
      check("waw_hold", 32'(waw_stall_o), 32'h1);
    end
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 3'd0, 1'b0);
    check("waw_issue", 32'(issue_o), 32'h1);
    idle();
    check("waw_stall_cnt", 32'(stall_cnt_o), 32'd9);

    // Write-port conflict: mul x3 (lat 3), gap, load x4 (lat 1) lands on same cycle.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 3'd3, 1'b0);
    idle();
    check("wb_idle_nostall", 32'(stall_o), 32'h0);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 3'd1, 1'b0);
    check("wb_flag", 32'(wb_stall_o), 32'h1);
    check("wb_noraw", 32'(raw_stall_o), 32'h0);
    check("wb_nowaw", 32'(waw_stall_o), 32'h0);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 3'd1, 1'b0);
    check("wb_issue", 32'(issue_o), 32'h1);
    idle();
    check("wb_stall_cnt", 32'(stall_cnt_o), 32'd10);

    // Flush of a stalled consumer: no issue, producer keeps counting down.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 3'd3, 1'b0);
    drive(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 3'd0, 1'b1);
    check("fl_issue", 32'(issue_o), 32'h0);
    check("fl_stall", 32'(stall_o), 32'h1);
    check("fl_busy", 32'(busy_o), 32'h0000_0800);
    drive(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 3'd0, 1'b1);
    check("fl_busy_keep", 32'(busy_o), 32'h0000_0800);
    idle();
    idle();
    check("fl_busy_drain", 32'(busy_o), 32'h0);
    check("fl_stall_cnt", 32'(stall_cnt_o), 32'd12);

    // x0 as source and destination never stalls and is never tracked.
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 3'd3, 1'b0);
    check("x0_issue", 32'(issue_o), 32'h1);
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 3'd2, 1'b0);
    check("x0_nostall", 32'(stall_o), 32'h0);
    check("x0_busy", 32'(busy_o), 32'h0);

    // Counter saturation: two more 3-bubble chains push 12 -> 15 -> stays 15.
    for (int n = 0; n < 2; n++) begin
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 3'd3, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b1, 5'd13, 1'b1, 5'd0, 1'b0, 5'd14, 1'b0, 3'd0, 1'b0);
      check("sat_issue", 32'(issue_o), 32'h1);
      idle();
    end
    check("sat_cnt", 32'(stall_cnt_o), 32'd15);

    // Asynchronous reset mid-stall.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 3'd3, 1'b0);
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 3'd0, 1'b0);
    check("ar_stall_before", 32'(stall_o), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_stall", 32'(stall_o), 32'h0);
    check("ar_busy", 32'(busy_o), 32'h0);
    check("ar_cnt", 32'(stall_cnt_o), 32'h0);
    check("ar_issue", 32'(issue_o), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
